prospect_car_sensor: RTL
========================

Name: prospect_car_sensor

Overview:
Vehicle-detection front end for the Prospect approach. It is the producer of the car_present input that the stoplight controller consumes. It debounces a raw inductive-loop signal, counts cars queued at the Prospect stop line, and retires cars on exit-loop departure pulses, qualified by the current Prospect light. car_present is high whenever the queue is non-empty.

Parameters:
DEBOUNCE, 2, number of consecutive synchronized samples beyond the first required to accept a loop level change (legal range 1..15)
QW, 4, width of the queue counter; queue saturates at 2^QW-1

Ports:
clk  input  1  system clock (one tick = 5 s of simulated time)
rst  input  1  asynchronous, active-high reset
loop_raw  input  1  raw stop-line loop detector, asynchronous to clk, may glitch
depart  input  1  single-cycle pulse: one car has crossed the exit loop
light_pros  input  3  Prospect light, one-hot: GRN=3'b100, YLW=3'b010, RED=3'b001
car_present  output  1  registered; 1 when queue_count != 0
queue_count  output  QW  registered number of cars waiting
arrival  output  1  registered single-cycle pulse per accepted car
overflow  output  1  sticky; set on an arrival while the queue is full
light_err  output  1  registered; 1 while light_pros is not a legal one-hot code

Behaviour:
- Reset (async, rst=1): synchronizer flops=0, FSM=IDLE, debounce counter=0, queue_count=0, car_present=0, arrival=0, overflow=0, light_err=0. Reset mid-operation discards the queue and any pending debounce.
- loop_raw passes through a 2-flop synchronizer; s is the output of the 2nd flop. The FSM only observes s.
- Debounce FSM states: IDLE, RISE_WAIT, OCCUPIED, FALL_WAIT.
  - IDLE: s=1 -> RISE_WAIT, cnt=0.
  - RISE_WAIT: s=0 -> IDLE. If cnt==DEBOUNCE-1 -> OCCUPIED and accept an arrival. Otherwise cnt++.
  - OCCUPIED: s=0 -> FALL_WAIT, cnt=0.
  - FALL_WAIT: s=1 -> OCCUPIED with no new arrival. If cnt==DEBOUNCE-1 -> IDLE. Otherwise cnt++.
- Latency: loop_raw is first sampled high at edge 0. queue_count, car_present and arrival update at edge DEBOUNCE+2 (edge 4 for DEBOUNCE=2). arrival is high for exactly one cycle.
- Departure qualification:
  - A depart pulse is accepted when light_pros==GRN or YLW.
  - When light_pros==RED, acceptance depends on the optional feature.
  - A depart pulse is always ignored when the light is illegal.
- Queue update each edge (a = accepted arrival, d = accepted departure):
  - a and d together: count unchanged.
  - a only: count+1; if count == 2^QW-1, hold and set overflow.
  - d only: count-1; if count == 0, ignore (no underflow wrap).
- car_present is registered from the next-state count, so it changes on the same edge as queue_count.
- light_err is registered each edge from the current light_pros. Any value other than 100/010/001, including 000, sets it.
- overflow clears only on rst.

Optional Feature:
Macro RTOR_EN (right turn on red).
- Defined: a depart pulse while light_pros==RED is accepted and decrements the queue.
- Undefined: a depart pulse while light_pros==RED is ignored; queue_count is unchanged.

Test Plan:
1. rst pulse, then loop_raw high for 1 cycle only -> FSM returns to IDLE; arrival never asserts; queue_count=0; car_present=0.
2. loop_raw high for 6 cycles, then low -> exactly one arrival pulse at edge 4; queue_count=1; car_present=1; no second arrival on release.
3. queue_count=1, light_pros=GRN, depart pulse -> queue_count=0 and car_present=0 after that edge; a second depart leaves count at 0.
4. 16 separate debounced arrivals, no departures -> queue_count saturates at 15; overflow=1 on the 16th and stays 1; rst clears both to 0.
5. queue_count=3, accepted arrival and GRN depart on the same edge -> queue_count stays 3; arrival still pulses.
6. queue_count=2, light_pros=RED, depart pulse -> 1 with RTOR_EN, 2 without. Then light_pros=3'b110 -> light_err=1 next edge and a depart is ignored.

Source files
------------

// File: rtl/prospect_car_sensor.sv
// Prospect approach vehicle detector: synchronized, debounced loop with a saturating car queue.
// Build option: define RTOR_EN to let departures on a red light (right turn on red) retire cars.
module prospect_car_sensor #(
  parameter int DEBOUNCE = 2,
  parameter int QW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loop_raw,
  input  logic          depart,
  input  logic [2:0]    light_pros,
  output logic          car_present,
  output logic [QW-1:0] queue_count,
  output logic          arrival,
  output logic          overflow,
  output logic          light_err
);

  // state     | meaning
  // IDLE      | loop empty, waiting for a rising level
  // RISE_WAIT | loop high, counting samples before accepting a car
  // OCCUPIED  | car accepted, loop still covered
  // FALL_WAIT | loop low, counting samples before declaring it empty
  typedef enum logic [1:0] {IDLE, RISE_WAIT, OCCUPIED, FALL_WAIT} state_t;

  localparam logic [2:0]    LIGHT_GRN = 3'b100;
  localparam logic [2:0]    LIGHT_YLW = 3'b010;
  localparam logic [2:0]    LIGHT_RED = 3'b001;
  localparam logic [3:0]    CNT_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [QW-1:0] Q_MAX     = '1;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [3:0]    r_cnt;

  logic          w_arrive;
  logic          w_light_ok;
  logic          w_dep_ok;
  logic          w_depart;
  logic [QW-1:0] w_q_next;
  logic          w_ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= loop_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_arrive   = (r_state == RISE_WAIT) && r_sync2 && (r_cnt == CNT_LAST);
  assign w_light_ok = (light_pros == LIGHT_GRN) || (light_pros == LIGHT_YLW) ||
                      (light_pros == LIGHT_RED);

`ifdef RTOR_EN
  assign w_dep_ok = w_light_ok;
`else
  assign w_dep_ok = (light_pros == LIGHT_GRN) || (light_pros == LIGHT_YLW);
`endif

  assign w_depart = depart && w_dep_ok;

  // A simultaneous arrival and departure cancel, so a full queue does not flag overflow.
  always_comb begin
    w_q_next  = queue_count;
    w_ovf_set = 1'b0;
    case ({w_arrive, w_depart})
      2'b10: begin
        if (queue_count == Q_MAX) w_ovf_set = 1'b1;
        else                      w_q_next  = queue_count + 1'b1;
      end
      2'b01: begin
        if (queue_count != '0) w_q_next = queue_count - 1'b1;
      end
      default: w_q_next = queue_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      queue_count <= '0;
      car_present <= 1'b0;
      arrival     <= 1'b0;
      overflow    <= 1'b0;
      light_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= RISE_WAIT;
            r_cnt   <= '0;
          end
        end
        RISE_WAIT: begin
          if (!r_sync2)               r_state <= IDLE;
          else if (r_cnt == CNT_LAST) r_state <= OCCUPIED;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        OCCUPIED: begin
          if (!r_sync2) begin
            r_state <= FALL_WAIT;
            r_cnt   <= '0;
          end
        end
        FALL_WAIT: begin
          if (r_sync2)                r_state <= OCCUPIED;
          else if (r_cnt == CNT_LAST) r_state <= IDLE;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      queue_count <= w_q_next;
      car_present <= (w_q_next != '0);
      arrival     <= w_arrive;
      overflow    <= overflow | w_ovf_set;
      light_err   <= !w_light_ok;
    end
  end

endmodule
